// File: rtl/axi_dma_pkg.sv
// Shared constants, default descriptor types and helpers for the AXI DMA burst splitter.
package axi_dma_pkg;

   localparam int unsigned PageSize  = 4096;
   localparam int unsigned MaxBeats  = 256;
   localparam int unsigned PageOffW  = 12;
   localparam int unsigned ByteW     = 13;  // holds 0..PageSize
   localparam int unsigned IdW       = 4;
   localparam int unsigned CacheW    = 4;
   localparam int unsigned DescAddrW = 64;
   localparam int unsigned DescOffW  = 8;
   localparam logic [1:0]  BurstIncr = 2'b01;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } split_state_e;

   typedef struct packed {
      logic [IdW-1:0]       id;
      logic [DescAddrW-1:0] src;
      logic [DescAddrW-1:0] dst;
      logic [DescAddrW-1:0] num_bytes;
      logic [CacheW-1:0]    cache_src;
      logic [CacheW-1:0]    cache_dst;
   } burst_req_def_t;

   typedef struct packed {
      logic [IdW-1:0]       id;
      logic [DescAddrW-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic [CacheW-1:0]    cache;
      logic                 last;
   } ax_desc_t;

   typedef struct packed {
      logic [DescOffW-1:0] offset;
      logic [DescOffW-1:0] tailer;
      logic [DescOffW-1:0] shift;
   } r_desc_t;

   typedef struct packed {
      logic [DescOffW-1:0] offset;
      logic [DescOffW-1:0] tailer;
      logic [7:0]          num_beats;
      logic                is_single;
   } w_desc_t;

   typedef struct packed {
      ax_desc_t ar;
      r_desc_t  r;
   } read_req_def_t;

   typedef struct packed {
      ax_desc_t aw;
      w_desc_t  w;
   } write_req_def_t;

   function automatic logic [ByteW-1:0] min_bytes(input logic [ByteW-1:0] a,
                                                  input logic [ByteW-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_dma_page_split.sv
// Per-side burst geometry: byte limit before a page or max-beat boundary, plus len/offset/tailer.
module axi_dma_page_split
   import axi_dma_pkg::*;
#(
   parameter  int unsigned DataWidth = 64,
   localparam int unsigned StrbWidth = DataWidth / 8,
   localparam int unsigned OffW      = $clog2(StrbWidth)
) (
   input  logic [PageOffW-1:0] addr,
   input  logic [ByteW-1:0]    num_bytes,
   output logic [ByteW-1:0]    limit,
   output logic [7:0]          len,
   output logic [OffW-1:0]     offset,
   output logic [OffW-1:0]     tailer
);

   logic [31:0] page_lim;
   logic [31:0] beat_lim;
   logic [31:0] span;
   logic [31:0] beats;

   always_comb begin
      offset   = addr[OffW-1:0];
      page_lim = PageSize - 32'(addr);
      beat_lim = MaxBeats * StrbWidth - 32'(offset);
      limit    = ByteW'((beat_lim < page_lim) ? beat_lim : page_lim);
      // Beats cover the leading offset plus the payload, rounded up to whole words.
      span     = 32'(offset) + 32'(num_bytes);
      beats    = (span + StrbWidth - 32'd1) >> OffW;
      len      = 8'(beats - 32'd1);
      tailer   = OffW'(StrbWidth - 32'(span[OffW-1:0]));
   end

endmodule

// File: rtl/axi_dma_burst_splitter.sv
// Splits a 1D DMA transfer into AXI-legal read/write burst descriptor pairs.
module axi_dma_burst_splitter
   import axi_dma_pkg::*;
#(
   parameter  int unsigned DataWidth   = 64,
   parameter  int unsigned AddrWidth   = 64,
   parameter  type         burst_req_t = axi_dma_pkg::burst_req_def_t,
   parameter  type         read_req_t  = axi_dma_pkg::read_req_def_t,
   parameter  type         write_req_t = axi_dma_pkg::write_req_def_t,
   localparam int unsigned StrbWidth   = DataWidth / 8,
   localparam int unsigned OffW        = $clog2(StrbWidth)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  burst_req_t burst_req_i,
   input  logic       valid_i,
   output logic       ready_o,
   output read_req_t  read_req_o,
   output write_req_t write_req_o,
   output logic       r_valid_o,
   input  logic       r_ready_i,
   output logic       w_valid_o,
   input  logic       w_ready_i,
   output logic       idle_o
);

   split_state_e         state_q;
   logic [AddrWidth-1:0] src_q;
   logic [AddrWidth-1:0] dst_q;
   logic [AddrWidth-1:0] rem_q;
   logic [IdW-1:0]       id_q;
   logic [CacheW-1:0]    cache_src_q;
   logic [CacheW-1:0]    cache_dst_q;
   logic                 r_done_q;
   logic                 w_done_q;

   logic [ByteW-1:0] src_limit, dst_limit, rem_cap, n;
   logic [7:0]       ar_len, aw_len;
   logic [OffW-1:0]  src_off, dst_off, r_tail, w_tail, shift;
   logic             last, r_fin, w_fin;

   axi_dma_page_split #(.DataWidth(DataWidth)) i_src_split (
      .addr      (src_q[PageOffW-1:0]),
      .num_bytes (n),
      .limit     (src_limit),
      .len       (ar_len),
      .offset    (src_off),
      .tailer    (r_tail)
   );

   axi_dma_page_split #(.DataWidth(DataWidth)) i_dst_split (
      .addr      (dst_q[PageOffW-1:0]),
      .num_bytes (n),
      .limit     (dst_limit),
      .len       (aw_len),
      .offset    (dst_off),
      .tailer    (w_tail)
   );

   always_comb begin
      rem_cap = (rem_q > AddrWidth'(PageSize)) ? ByteW'(PageSize) : ByteW'(rem_q);
      n       = min_bytes(min_bytes(rem_cap, src_limit), dst_limit);
      last    = (AddrWidth'(n) == rem_q);
      shift   = src_off - dst_off;
   end

   assign ready_o   = (state_q == StIdle);
   assign idle_o    = (state_q == StIdle);
   assign r_valid_o = (state_q == StBusy) && !r_done_q;
   assign w_valid_o = (state_q == StBusy) && !w_done_q;
   assign r_fin     = r_done_q || (r_valid_o && r_ready_i);
   assign w_fin     = w_done_q || (w_valid_o && w_ready_i);

   // Descriptor pair, derived purely from held state so it is stable until handshaked.
   always_comb begin
      read_req_o             = '0;
      read_req_o.ar.id       = id_q;
      read_req_o.ar.addr     = src_q;
      read_req_o.ar.len      = ar_len;
      read_req_o.ar.size     = 3'(OffW);
      read_req_o.ar.burst    = BurstIncr;
      read_req_o.ar.cache    = cache_src_q;
      read_req_o.ar.last     = last;
      read_req_o.r.offset    = DescOffW'(src_off);
      read_req_o.r.tailer    = DescOffW'(r_tail);
      read_req_o.r.shift     = DescOffW'(shift);

      write_req_o            = '0;
      write_req_o.aw.id      = id_q;
      write_req_o.aw.addr    = dst_q;
      write_req_o.aw.len     = aw_len;
      write_req_o.aw.size    = 3'(OffW);
      write_req_o.aw.burst   = BurstIncr;
      write_req_o.aw.cache   = cache_dst_q;
      write_req_o.aw.last    = last;
      write_req_o.w.offset    = DescOffW'(dst_off);
      write_req_o.w.tailer    = DescOffW'(w_tail);
      write_req_o.w.num_beats = aw_len;
      write_req_o.w.is_single = (aw_len == 8'd0);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         src_q       <= '0;
         dst_q       <= '0;
         rem_q       <= '0;
         id_q        <= '0;
         cache_src_q <= '0;
         cache_dst_q <= '0;
         r_done_q    <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               // Zero-length transfers are consumed here without leaving IDLE.
               if (valid_i && (burst_req_i.num_bytes != '0)) begin
                  src_q       <= AddrWidth'(burst_req_i.src);
                  dst_q       <= AddrWidth'(burst_req_i.dst);
                  rem_q       <= AddrWidth'(burst_req_i.num_bytes);
                  id_q        <= burst_req_i.id;
                  cache_src_q <= burst_req_i.cache_src;
                  cache_dst_q <= burst_req_i.cache_dst;
                  r_done_q    <= 1'b0;
                  w_done_q    <= 1'b0;
                  state_q     <= StBusy;
               end
            end
            StBusy: begin
               if (r_fin && w_fin) begin
                  src_q    <= src_q + AddrWidth'(n);
                  dst_q    <= dst_q + AddrWidth'(n);
                  rem_q    <= rem_q - AddrWidth'(n);
                  r_done_q <= 1'b0;
                  w_done_q <= 1'b0;
                  if (last) state_q <= StIdle;
               end else begin
                  r_done_q <= r_fin;
                  w_done_q <= w_fin;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_dma_burst_splitter.sv
// Scoreboard bench for axi_dma_burst_splitter: directed corner cases plus randomized transfers.
module tb_axi_dma_burst_splitter;
   import axi_dma_pkg::*;

   localparam longint unsigned STRB = 8;
   localparam longint unsigned PAGE = 4096;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   burst_req_def_t burst_req_i;
   logic           valid_i;
   logic           ready_o;
   read_req_def_t  read_req_o;
   write_req_def_t write_req_o;
   logic           r_valid_o, r_ready_i, w_valid_o, w_ready_i, idle_o;

   logic [1:0] mode;
   logic       r_rand = 1'b1, w_rand = 1'b1, r_force, w_force;

   int n_vec = 0;
   int n_err = 0;

   read_req_def_t  exp_r[$];
   write_req_def_t exp_w[$];

   axi_dma_burst_splitter #(.DataWidth(64), .AddrWidth(64)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .burst_req_i (burst_req_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .read_req_o  (read_req_o),
      .write_req_o (write_req_o),
      .r_valid_o   (r_valid_o),
      .r_ready_i   (r_ready_i),
      .w_valid_o   (w_valid_o),
      .w_ready_i   (w_ready_i),
      .idle_o      (idle_o)
   );

   always #5 clk_i = ~clk_i;

   // mode 0: readies high, 1: random, 2: forced by the main sequence
   assign r_ready_i = (mode == 2'd0) ? 1'b1 : ((mode == 2'd1) ? r_rand : r_force);
   assign w_ready_i = (mode == 2'd0) ? 1'b1 : ((mode == 2'd1) ? w_rand : w_force);

   initial forever begin
      @(posedge clk_i);
      #1;
      r_rand = ($urandom_range(0, 3) != 0);
      w_rand = ($urandom_range(0, 3) != 0);
   end

   // Reference: walk the transfer with plain arithmetic, cutting at page and max-burst boundaries.
   function automatic void model(input burst_req_def_t b);
      longint unsigned s, d, rem, n, so, dof, lim;
      read_req_def_t   er;
      write_req_def_t  ew;
      s = b.src; d = b.dst; rem = b.num_bytes;
      while (rem != 0) begin
         so  = s % STRB;
         dof = d % STRB;
         n   = rem;
         lim = PAGE - (s % PAGE);      if (lim < n) n = lim;
         lim = PAGE - (d % PAGE);      if (lim < n) n = lim;
         lim = 256 * STRB - so;        if (lim < n) n = lim;
         lim = 256 * STRB - dof;       if (lim < n) n = lim;
         er = '0;
         er.ar.id    = b.id;
         er.ar.addr  = s;
         er.ar.len   = 8'((so + n + STRB - 1) / STRB - 1);
         er.ar.size  = 3'd3;
         er.ar.burst = 2'b01;
         er.ar.cache = b.cache_src;
         er.ar.last  = (n == rem);
         er.r.offset = 8'(so);
         er.r.tailer = 8'((STRB - (so + n) % STRB) % STRB);
         er.r.shift  = 8'((so + STRB - dof) % STRB);
         ew = '0;
         ew.aw.id    = b.id;
         ew.aw.addr  = d;
         ew.aw.len   = 8'((dof + n + STRB - 1) / STRB - 1);
         ew.aw.size  = 3'd3;
         ew.aw.burst = 2'b01;
         ew.aw.cache = b.cache_dst;
         ew.aw.last  = (n == rem);
         ew.w.offset    = 8'(dof);
         ew.w.tailer    = 8'((STRB - (dof + n) % STRB) % STRB);
         ew.w.num_beats = ew.aw.len;
         ew.w.is_single = (ew.aw.len == 8'd0);
         exp_r.push_back(er);
         exp_w.push_back(ew);
         s += n; d += n; rem -= n;
      end
   endfunction

   // Monitor: sample on the falling edge; a valid&ready here handshakes at the next rising edge.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_r.delete();
         exp_w.delete();
      end else begin
         if (r_valid_o && r_ready_i) begin
            n_vec++;
            if (exp_r.size() == 0) begin
               n_err++;
               $display("FAIL r_unexpected act=%h req=<none>", read_req_o);
            end else begin
               if (read_req_o !== exp_r[0]) begin
                  n_err++;
                  $display("FAIL r_desc act=%h req=%h", read_req_o, exp_r[0]);
               end
               void'(exp_r.pop_front());
            end
         end
         if (w_valid_o && w_ready_i) begin
            n_vec++;
            if (exp_w.size() == 0) begin
               n_err++;
               $display("FAIL w_unexpected act=%h req=<none>", write_req_o);
            end else begin
               if (write_req_o !== exp_w[0]) begin
                  n_err++;
                  $display("FAIL w_desc act=%h req=%h", write_req_o, exp_w[0]);
               end
               void'(exp_w.pop_front());
            end
         end
      end
   end

   task automatic check_bit(input string nm, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s act=%b req=%b", nm, act, req);
      end
   endtask

   task automatic issue(input logic [63:0] s, input logic [63:0] d, input logic [63:0] nb);
      burst_req_def_t b;
      int             waited;
      b.id        = 4'($urandom);
      b.src       = s;
      b.dst       = d;
      b.num_bytes = nb;
      b.cache_src = 4'($urandom);
      b.cache_dst = 4'($urandom);
      @(posedge clk_i);
      #1;
      burst_req_i = b;
      valid_i     = 1'b1;
      waited      = 0;
      @(negedge clk_i);
      while (!ready_o && waited < 5000) begin
         @(negedge clk_i);
         waited++;
      end
      if (!ready_o) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout act=ready_low req=ready_high");
      end else begin
         model(b);
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain_and_check_idle(input string nm);
      int waited;
      waited = 0;
      while ((exp_r.size() != 0 || exp_w.size() != 0) && waited < 5000) begin
         @(posedge clk_i);
         #1;
         waited++;
      end
      n_vec++;
      if (exp_r.size() != 0 || exp_w.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain act=%0d/%0d_pending req=0/0", nm, exp_r.size(), exp_w.size());
      end
      @(negedge clk_i);
      check_bit({nm, "_idle"}, idle_o, 1'b1);
   endtask

   initial begin
      logic [63:0] s, d, nb;
      mode        = 2'd0;
      r_force     = 1'b0;
      w_force     = 1'b0;
      valid_i     = 1'b0;
      burst_req_i = '0;
      rst_ni      = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_bit("rst_ready", ready_o, 1'b1);
      check_bit("rst_idle", idle_o, 1'b1);
      check_bit("rst_rvalid", r_valid_o, 1'b0);
      check_bit("rst_wvalid", w_valid_o, 1'b0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      issue(64'h0, 64'h0, 64'd64);                       drain_and_check_idle("aligned64");
      issue(64'hFF8, 64'h2000, 64'd16);                  drain_and_check_idle("page_cross");
      issue(64'h3, 64'h5, 64'd10);                       drain_and_check_idle("unaligned");
      issue(64'h0, 64'h0, 64'd4096);                     drain_and_check_idle("max_beats");
      issue(64'hFFFF_FFFF_FFFF_FFF0, 64'h104, 64'd40);   drain_and_check_idle("addr_wrap");

      // w side stalls for three cycles while r completes
      mode = 2'd2; r_force = 1'b1; w_force = 1'b0;
      issue(64'hFF8, 64'h2000, 64'd16);
      @(negedge clk_i);
      check_bit("stall_c1_r", r_valid_o, 1'b1);
      check_bit("stall_c1_w", w_valid_o, 1'b1);
      @(negedge clk_i);
      check_bit("stall_c2_r", r_valid_o, 1'b0);
      check_bit("stall_c2_w", w_valid_o, 1'b1);
      @(negedge clk_i);
      check_bit("stall_c3_r", r_valid_o, 1'b0);
      check_bit("stall_c3_w", w_valid_o, 1'b1);
      @(posedge clk_i);
      #1;
      w_force = 1'b1;
      @(negedge clk_i);
      check_bit("stall_c4_w", w_valid_o, 1'b1);
      @(negedge clk_i);
      check_bit("stall_next_r", r_valid_o, 1'b1);
      check_bit("stall_next_w", w_valid_o, 1'b1);
      mode = 2'd0;
      drain_and_check_idle("stall");

      // zero-length transfer is swallowed
      issue(64'h40, 64'h80, 64'd0);
      @(negedge clk_i);
      check_bit("zero_idle", idle_o, 1'b1);
      check_bit("zero_ready", ready_o, 1'b1);
      check_bit("zero_rvalid", r_valid_o, 1'b0);
      check_bit("zero_wvalid", w_valid_o, 1'b0);

      // reset in the middle of a multi-burst transfer
      mode = 2'd2; r_force = 1'b0; w_force = 1'b0;
      issue(64'h0, 64'h0, 64'd6000);
      @(negedge clk_i);
      check_bit("mid_rvalid", r_valid_o, 1'b1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check_bit("rstmid_rvalid", r_valid_o, 1'b0);
      check_bit("rstmid_wvalid", w_valid_o, 1'b0);
      check_bit("rstmid_ready", ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      rst_ni  = 1'b1;
      r_force = 1'b1;
      w_force = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         check_bit("post_rst_rvalid", r_valid_o, 1'b0);
      end

      // randomized transfers with random back-pressure
      mode = 2'd1;
      for (int t = 0; t < 60; t++) begin
         s = {$urandom, $urandom};
         d = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) s[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
         if ($urandom_range(0, 2) == 0) d[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
         case ($urandom_range(0, 9))
            0:             nb = 64'd0;
            1, 2, 3, 4, 5: nb = 64'($urandom_range(1, 64));
            default:       nb = 64'($urandom_range(1, 9000));
         endcase
         issue(s, d, nb);
      end
      drain_and_check_idle("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
